// File: rtl/enemy_fire_scheduler_pkg.sv
// Shared constants and types for the enemy fire path.
// Pure declarations; no logic, so no latency or backpressure of its own.
package galaga_lib;

    localparam int NP_ENEMY        = 10;
    localparam int NE_ENEMY        = 8;
    localparam int ENEMY_CD_FRAMES = 4;
    localparam int ENEMY_MAX_LIVE  = 6;

    typedef enum logic {SCHED_IDLE, SCHED_COOL} sched_state_t;

endpackage

// File: rtl/enemy_fire_scheduler_rr_pick.sv
// Rotating priority encoder: first set req bit at or after ptr, wrapping N-1 -> 0.
// Purely combinational, zero latency; has no flow control of its own.
module rr_pick #(
    parameter  int N = 8,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    int j;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = W'(j);
            end
        end
    end

endmodule

// File: rtl/enemy_fire_scheduler.sv
// Round-robin enemy fire arbiter: grants one requester per frame onto the lowest free slot.
// Registered outputs, one frame after sampling; requests are ignored (not queued) during cooldown.
module enemy_fire_scheduler
    import galaga_lib::*;
#(
    parameter  int NP        = NP_ENEMY,
    parameter  int NE        = NE_ENEMY,
    parameter  int CD_FRAMES = ENEMY_CD_FRAMES,
    parameter  int MAX_LIVE  = ENEMY_MAX_LIVE,
    localparam int PW        = (NP > 1) ? $clog2(NP) : 1,
    localparam int EW        = (NE > 1) ? $clog2(NE) : 1,
    localparam int CW        = $clog2(CD_FRAMES + 1),
    localparam int KW        = $clog2(NP + 1)
) (
    input  logic          frame_clk,
    input  logic          Reset,
    input  logic          Enable,
    input  logic [NE-1:0] FireReq,
    input  logic [NP-1:0] ProjEn,
    output logic [NE-1:0] FireGnt,
    output logic [NP-1:0] ProjActvt,
    output logic [PW-1:0] GntSlot,
    output logic          CoolBusy
);

    if (CD_FRAMES < 1) begin : g_cd_chk
        $error("CD_FRAMES must be >= 1");
    end
    if (MAX_LIVE < 1 || MAX_LIVE > NP) begin : g_live_chk
        $error("MAX_LIVE must be within 1..NP");
    end

    sched_state_t  state, state_nx;
    logic [EW-1:0] rr_ptr, rr_nx;
    logic [CW-1:0] cd_cnt, cd_nx;
    logic [NE-1:0] gnt_nx;
    logic [NP-1:0] actvt_nx;
    logic [PW-1:0] slot_nx;

    logic          win_found, slot_found, grant_ok;
    logic [EW-1:0] win;
    logic [PW-1:0] slot;
    logic [KW-1:0] live;

    rr_pick #(.N(NE)) u_pick_enemy (
        .req   (FireReq),
        .ptr   (rr_ptr),
        .found (win_found),
        .idx   (win)
    );

    // Lowest free slot: same encoder with a fixed zero pointer over the free mask.
    rr_pick #(.N(NP)) u_pick_slot (
        .req   (~ProjEn),
        .ptr   ('0),
        .found (slot_found),
        .idx   (slot)
    );

    always_comb begin
        live = '0;
        for (int i = 0; i < NP; i++) live = live + KW'(ProjEn[i]);
    end

    assign grant_ok = Enable && win_found && slot_found && (live < KW'(MAX_LIVE));

    always_comb begin
        state_nx = state;
        rr_nx    = rr_ptr;
        cd_nx    = cd_cnt;
        gnt_nx   = '0;
        actvt_nx = '0;
        slot_nx  = '0;
        case (state)
            SCHED_IDLE: begin
                if (grant_ok) begin
                    gnt_nx   = NE'(1) << win;
                    actvt_nx = NP'(1) << slot;
                    slot_nx  = slot;
                    rr_nx    = (win == EW'(NE - 1)) ? '0 : win + 1'b1;
                    cd_nx    = CW'(CD_FRAMES - 1);
                    state_nx = SCHED_COOL;
                end
            end
            SCHED_COOL: begin
                if (cd_cnt != '0) cd_nx = cd_cnt - 1'b1;
                else              state_nx = SCHED_IDLE;
            end
            default: state_nx = SCHED_IDLE;
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state     <= SCHED_IDLE;
            rr_ptr    <= '0;
            cd_cnt    <= '0;
            FireGnt   <= '0;
            ProjActvt <= '0;
            GntSlot   <= '0;
            CoolBusy  <= 1'b0;
        end else begin
            state     <= state_nx;
            rr_ptr    <= rr_nx;
            cd_cnt    <= cd_nx;
            FireGnt   <= gnt_nx;
            ProjActvt <= actvt_nx;
            GntSlot   <= slot_nx;
            CoolBusy  <= (state_nx == SCHED_COOL);
        end
    end

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Scoreboard bench: a frame-level reference model queues expected grants and busy flags; a monitor checks them.
module tb_enemy_fire_scheduler;
    import galaga_lib::*;

    localparam int NP = NP_ENEMY;
    localparam int NE = NE_ENEMY;
    localparam int CD = ENEMY_CD_FRAMES;
    localparam int ML = ENEMY_MAX_LIVE;
    localparam int PW = $clog2(NP);

    logic          frame_clk;
    logic          Reset;
    logic          Enable;
    logic [NE-1:0] FireReq;
    logic [NP-1:0] ProjEn;
    logic [NE-1:0] FireGnt;
    logic [NP-1:0] ProjActvt;
    logic [PW-1:0] GntSlot;
    logic          CoolBusy;

    enemy_fire_scheduler dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .Enable    (Enable),
        .FireReq   (FireReq),
        .ProjEn    (ProjEn),
        .FireGnt   (FireGnt),
        .ProjActvt (ProjActvt),
        .GntSlot   (GntSlot),
        .CoolBusy  (CoolBusy)
    );

    typedef struct {
        int            edge_n;
        logic [NE-1:0] gnt;
        logic [NP-1:0] act;
        logic [PW-1:0] slot;
    } gexp_t;

    typedef struct {
        int   edge_n;
        logic cb;
    } sexp_t;

    gexp_t gq[$];
    sexp_t sq[$];
    gexp_t g;
    sexp_t s;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int edges_done = 0;

    // Model state: next requester to favour, and frames elapsed since the last grant.
    int m_rr = 0;
    int m_gap = CD;

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    always @(posedge frame_clk) edges_done <= edges_done + 1;

    task automatic step(input logic rst, input logic en,
                        input logic [NE-1:0] req, input logic [NP-1:0] pe);
        int w;
        int sl;
        gexp_t ge;
        sexp_t se;
        Reset   = rst;
        Enable  = en;
        FireReq = req;
        ProjEn  = pe;
        edge_cnt++;
        if (rst) begin
            m_rr  = 0;
            m_gap = CD;
        end else if (m_gap >= CD && en && req != 0 && pe != '1 && $countones(pe) < ML) begin
            w = -1;
            for (int k = 0; k < NE; k++)
                if (w < 0 && req[(m_rr + k) % NE]) w = (m_rr + k) % NE;
            sl = -1;
            for (int k = 0; k < NP; k++)
                if (sl < 0 && !pe[k]) sl = k;
            ge.edge_n = edge_cnt;
            ge.gnt    = NE'(1) << w;
            ge.act    = NP'(1) << sl;
            ge.slot   = PW'(sl);
            gq.push_back(ge);
            m_rr  = (w + 1) % NE;
            m_gap = 0;
        end else if (m_gap < CD) begin
            m_gap++;
        end
        se.edge_n = edge_cnt;
        se.cb     = (m_gap < CD);
        sq.push_back(se);
        @(posedge frame_clk);
        #1;
    endtask

    task automatic run(input int n, input logic rst, input logic en,
                       input logic [NE-1:0] req, input logic [NP-1:0] pe);
        for (int i = 0; i < n; i++) step(rst, en, req, pe);
    endtask

    always @(negedge frame_clk) begin
        if (sq.size() > 0 && sq[0].edge_n <= edges_done) begin
            s = sq.pop_front();
            checks++;
            if (CoolBusy !== s.cb) begin
                errors++;
                $display("FAIL coolbusy edge %0d: got %b want %b", s.edge_n, CoolBusy, s.cb);
            end
        end
        if (FireGnt != 0 || ProjActvt != 0) begin
            checks++;
            if (gq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_grant edge %0d: gnt %h act %h slot %0d, want none",
                         edges_done, FireGnt, ProjActvt, GntSlot);
            end else begin
                g = gq.pop_front();
                if (g.edge_n != edges_done || FireGnt !== g.gnt ||
                    ProjActvt !== g.act || GntSlot !== g.slot) begin
                    errors++;
                    $display("FAIL grant edge %0d: gnt %h act %h slot %0d, want edge %0d gnt %h act %h slot %0d",
                             edges_done, FireGnt, ProjActvt, GntSlot,
                             g.edge_n, g.gnt, g.act, g.slot);
                end
            end
        end else if (gq.size() > 0 && gq[0].edge_n <= edges_done) begin
            g = gq.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_grant edge %0d: got no pulse, want gnt %h act %h slot %0d",
                     g.edge_n, g.gnt, g.act, g.slot);
        end else begin
            checks++;
            if (GntSlot !== '0) begin
                errors++;
                $display("FAIL idle_slot edge %0d: got %0d want 0", edges_done, GntSlot);
            end
        end
    end

    initial begin
        int mode;
        logic [NP-1:0] pe;
        logic [NE-1:0] rq;

        // Reset held with all requests up, then first grant right after release.
        run(3, 1'b1, 1'b1, 8'hFF, '0);
        run(1, 1'b0, 1'b1, 8'hFF, '0);
        run(6, 1'b0, 1'b1, 8'h00, '0);

        // Alternating pair: enemy0, enemy2, enemy0 spaced CD+1 frames.
        run(2, 1'b1, 1'b1, 8'h00, '0);
        run(12, 1'b0, 1'b1, 8'b0000_0101, '0);
        run(6, 1'b0, 1'b1, 8'h00, '0);

        // Lowest free slot above busy ones.
        run(6, 1'b0, 1'b1, 8'h10, 10'b00_0000_0111);
        run(6, 1'b0, 1'b1, 8'h00, '0);

        // Pool full, then a slot frees (live-count limit still governs).
        run(10, 1'b0, 1'b1, 8'h01, 10'h3FF);
        run(3, 1'b0, 1'b1, 8'h01, 10'h3DF);
        run(6, 1'b0, 1'b1, 8'h00, '0);

        // Enable low blocks grants.
        run(6, 1'b0, 1'b0, 8'hFF, '0);

        // Steer the pointer to 7, then show the wrap from 7 back to 0.
        run(6, 1'b0, 1'b1, 8'h40, '0);
        run(12, 1'b0, 1'b1, 8'b1000_0001, '0);
        run(6, 1'b0, 1'b1, 8'h00, '0);

        // Live count at the limit, then one below it.
        run(6, 1'b0, 1'b1, 8'h01, 10'h03F);
        run(6, 1'b0, 1'b1, 8'h01, 10'h01F);
        run(6, 1'b0, 1'b1, 8'h00, '0);

        // Reset two frames into cooldown, grant right after release.
        run(1, 1'b0, 1'b1, 8'h02, '0);
        run(2, 1'b0, 1'b1, 8'h00, '0);
        run(1, 1'b1, 1'b1, 8'h04, '0);
        run(3, 1'b0, 1'b1, 8'h04, '0);

        for (int i = 0; i < 500; i++) begin
            mode = $urandom_range(0, 3);
            case (mode)
                0:       pe = NP'($urandom) & NP'($urandom);
                1:       pe = NP'($urandom);
                2:       pe = '1;
                default: pe = '0;
            endcase
            rq = ($urandom_range(0, 3) == 0) ? '0 : NE'($urandom);
            step($urandom_range(0, 59) == 0, $urandom_range(0, 9) != 0, rq, pe);
        end

        run(CD + 2, 1'b0, 1'b0, 8'h00, '0);
        @(negedge frame_clk);
        #1;
        checks++;
        if (gq.size() != 0 || sq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d grants %0d flags pending, want 0 0", gq.size(), sq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
